// File: rtl/wptr_full_if.sv
// Write-side FIFO pointer bus: producer request and synchronized read
// pointer in, RAM address/enable, Gray write pointer and flags out.
interface wptr_full_if #(
  parameter int addrsize = 8
);
  logic                winc;
  logic [addrsize:0]   wq2_rptr;
  logic [addrsize-1:0] waddr;
  logic [addrsize:0]   wptr;
  logic                wen;
  logic                full;
  logic                almost_full;
  logic [addrsize:0]   wlevel;
  logic                overflow;

  // Producer / environment side
  modport master (
    output winc, wq2_rptr,
    input  waddr, wptr, wen, full, almost_full, wlevel, overflow
  );

  // Pointer controller side
  modport slave (
    input  winc, wq2_rptr,
    output waddr, wptr, wen, full, almost_full, wlevel, overflow
  );
endinterface

// File: rtl/wptr_full.sv
// Write-domain pointer and flag controller for a dual-clock FIFO.
// Keeps the binary write address and Gray write pointer, and derives
// registered full / almost_full / level / sticky overflow from the read
// pointer already synchronized into this clock domain. Because that read
// pointer lags, all occupancy outputs err on the side of "more full".
module wptr_full #(
  parameter int addrsize    = 8,
  parameter int afull_level = 252
) (
  input  logic         clk,
  input  logic         rst_n,
  wptr_full_if.slave   bus
);

  localparam int          PW        = addrsize + 1;
  localparam logic [addrsize:0] AFULL_LVL = PW'(afull_level);

  logic [addrsize:0] wbin_q, wbin_d;
  logic [addrsize:0] wptr_q, wgray_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic [addrsize:0] wlevel_q, wlevel_d;
  logic              overflow_q, overflow_d;

  logic              accept;
  logic [addrsize:0] rgray;
  logic [addrsize:0] rbin;
  logic [addrsize:0] full_cmp;

  assign rgray = bus.wq2_rptr;

  // Gray-to-binary of the synchronized read pointer: XOR prefix from the MSB down
  assign rbin[addrsize] = rgray[addrsize];
  generate
    for (genvar gi = addrsize - 1; gi >= 0; gi--) begin : g_rbin
      assign rbin[gi] = rbin[gi+1] ^ rgray[gi];
    end
  endgenerate

  // Full when the next Gray write pointer equals the read pointer with its
  // top two bits inverted (one full wrap ahead in Gray space).
  assign full_cmp = {~rgray[addrsize:addrsize-1], rgray[addrsize-2:0]};

  // Next-state pointer, flag and level computation
  always_comb begin
    accept     = bus.winc & ~full_q;
    wbin_d     = wbin_q + {{addrsize{1'b0}}, accept};
    wgray_d    = (wbin_d >> 1) ^ wbin_d;
    full_d     = (wgray_d == full_cmp);
    wlevel_d   = wbin_d - rbin;
    afull_d    = (wlevel_d >= AFULL_LVL);
    overflow_d = overflow_q | (bus.winc & full_q);
  end

  // State registers; async reset discards everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q     <= '0;
      wptr_q     <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      wlevel_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wptr_q     <= wgray_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      wlevel_q   <= wlevel_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.waddr       = wbin_q[addrsize-1:0];
  assign bus.wptr        = wptr_q;
  assign bus.wen         = accept;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.wlevel      = wlevel_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full with addrsize=3, afull_level=6.
module tb_wptr_full;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   ncmp  = 0;
  int   nerr  = 0;

  wptr_full_if #(.addrsize(3)) bus ();

  wptr_full #(.addrsize(3), .afull_level(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are settled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " wptr"},  32'(bus.wptr), 0);
    chk({tag, " waddr"}, 32'(bus.waddr), 0);
    chk({tag, " full"},  32'(bus.full), 0);
    chk({tag, " afull"}, 32'(bus.almost_full), 0);
    chk({tag, " wlevel"}, 32'(bus.wlevel), 0);
    chk({tag, " ovf"},   32'(bus.overflow), 0);
  endtask

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    logic [3:0] prev;
    logic [3:0] expg;

    bus.winc     = 1'b0;
    bus.wq2_rptr = 4'd0;

    // Reset then idle
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_reset_vals($sformatf("idle%0d", c));
    end

    // Fill from empty
    bus.winc = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("fill waddr%0d", k), 32'(bus.waddr), k);
      chk($sformatf("fill wen%0d", k), 32'(bus.wen), 1);
      tick();
      chk($sformatf("fill wlevel%0d", k), 32'(bus.wlevel), k + 1);
      chk($sformatf("fill afull%0d", k), 32'(bus.almost_full), (k >= 5) ? 1 : 0);
      chk($sformatf("fill full%0d", k), 32'(bus.full), (k == 7) ? 1 : 0);
    end
    chk("fill wptr", 32'(bus.wptr), 32'hC);
    chk("fill ovf before", 32'(bus.overflow), 0);
    chk("9th wen", 32'(bus.wen), 0);
    tick();
    chk("9th wptr hold", 32'(bus.wptr), 32'hC);
    chk("9th waddr hold", 32'(bus.waddr), 0);
    chk("9th full", 32'(bus.full), 1);
    chk("9th ovf", 32'(bus.overflow), 1);

    // Overflow sticky, read pointer advances by one
    bus.winc     = 1'b0;
    bus.wq2_rptr = 4'b0001;
    tick();
    chk("rd1 full", 32'(bus.full), 0);
    chk("rd1 wlevel", 32'(bus.wlevel), 7);
    chk("rd1 afull", 32'(bus.almost_full), 1);
    chk("rd1 ovf sticky", 32'(bus.overflow), 1);
    tick();
    chk("rd1 ovf sticky2", 32'(bus.overflow), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("ovf rst");
    bus.wq2_rptr = 4'd0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("ovf after rst", 32'(bus.overflow), 0);

    // Wrap-around: single writes, read pointer catches up each time
    prev = 4'd0;
    for (int i = 0; i < 20; i++) begin
      bus.winc = 1'b1;
      tick();
      expg = gray4(4'((i + 1) % 16));
      chk($sformatf("wrap wptr%0d", i), 32'(bus.wptr), 32'(expg));
      chk($sformatf("wrap ham%0d", i), $countones(bus.wptr ^ prev), 1);
      chk($sformatf("wrap waddr%0d", i), 32'(bus.waddr), (i + 1) % 8);
      chk($sformatf("wrap wlevel%0d", i), 32'(bus.wlevel), 1);
      chk($sformatf("wrap full%0d", i), 32'(bus.full), 0);
      prev = expg;
      bus.winc     = 1'b0;
      bus.wq2_rptr = expg;
      tick();
      chk($sformatf("wrap drain%0d", i), 32'(bus.wlevel), 0);
    end

    // Async reset mid-fill after 5 writes
    #2 rst_n = 1'b0;
    bus.wq2_rptr = 4'd0;
    tick();
    rst_n = 1'b1;
    bus.winc = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("mid wlevel", 32'(bus.wlevel), 5);
    chk("mid waddr", 32'(bus.waddr), 5);
    bus.winc = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("mid rst");
    tick();
    rst_n = 1'b1;

    // Gray check across 16 continuous accepts, read pointer trailing by one
    prev = 4'd0;
    bus.winc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      expg = gray4(4'((i + 1) % 16));
      chk($sformatf("gray ham%0d", i), $countones(bus.wptr ^ prev), 1);
      chk($sformatf("gray lvl%0d", i), 32'(bus.wlevel), 1);
      prev = expg;
      bus.wq2_rptr = expg;
    end
    // wbin is now 0; read pointer at binary 8 means a full wrap ahead
    bus.winc     = 1'b0;
    bus.wq2_rptr = 4'b1100;
    tick();
    chk("wrapfull wptr", 32'(bus.wptr), 0);
    chk("wrapfull full", 32'(bus.full), 1);
    chk("wrapfull wlevel", 32'(bus.wlevel), 8);
    chk("wrapfull afull", 32'(bus.almost_full), 1);
    bus.winc = 1'b1;
    #1;
    chk("wrapfull wen", 32'(bus.wen), 0);
    tick();
    chk("wrapfull hold", 32'(bus.wptr), 0);
    chk("wrapfull ovf", 32'(bus.overflow), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
